ulpi_reg_arbiter: RTL and testbench

Shares the single ULPI PHY register-access port between two requesters: port A (the power-up/configuration sequencer) and port B (the host command path). One transaction runs at a time; a watchdog terminates transactions the PHY never acknowledges. It sits between the requesters and the ULPI link block's REG_* interface, in the CLK domain.

---
 rtl/ulpi_reg_arbiter.sv | 155 +++++++++++++++
 tb/tb_ulpi_reg_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ulpi_reg_arbiter.sv
// Two-requester arbiter for the ULPI PHY register port: one transaction at a time,
// round-robin or fixed priority, with a watchdog that aborts unacknowledged requests.
module ulpi_reg_arbiter #(
  parameter int unsigned TIMEOUT    = 1024,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       a_req_i,
  input  logic       a_we_i,
  input  logic [5:0] a_addr_i,
  input  logic [7:0] a_wdata_i,
  output logic       a_ack_o,
  output logic [7:0] a_rdata_o,
  output logic       a_err_o,
  input  logic       b_req_i,
  input  logic       b_we_i,
  input  logic [5:0] b_addr_i,
  input  logic [7:0] b_wdata_i,
  output logic       b_ack_o,
  output logic [7:0] b_rdata_o,
  output logic       b_err_o,
  output logic [5:0] reg_addr_o,
  output logic [7:0] reg_data_write_o,
  output logic       reg_write_req_o,
  output logic       reg_read_req_o,
  input  logic       reg_write_ack_i,
  input  logic       reg_read_ack_i,
  input  logic [7:0] reg_data_read_i,
  output logic       busy_o,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        gnt_b_q, gnt_b_d;
  logic        last_b_q, last_b_d;
  logic        we_q, we_d;
  logic [5:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic        a_err_q, a_err_d, b_err_q, b_err_d;
  logic        pick_b;
  logic        matched;

  // Requester handshake: REQ is a level held (with WE/ADDR/WDATA stable) until the
  // one-cycle ACK; downstream REG_*_REQ is a level held until the matching REG_*_ACK.
  assign pick_b  = b_req_i && (!a_req_i || (!FIXED_PRIO && !last_b_q));
  assign matched = we_q ? reg_write_ack_i : reg_read_ack_i;

  always_comb begin
    state_d   = state_q;
    gnt_b_d   = gnt_b_q;
    last_b_d  = last_b_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    a_rdata_d = a_rdata_q;
    a_err_d   = a_err_q;
    b_rdata_d = b_rdata_q;
    b_err_d   = b_err_q;
    case (state_q)
      ST_IDLE: begin
        if (a_req_i || b_req_i) begin
          gnt_b_d = pick_b;
          we_d    = pick_b ? b_we_i    : a_we_i;
          addr_d  = pick_b ? b_addr_i  : a_addr_i;
          wdata_d = pick_b ? b_wdata_i : a_wdata_i;
          cnt_d   = 16'd0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (matched) begin
          // Writes leave the port's last read data untouched.
          if (gnt_b_q) begin
            if (!we_q) b_rdata_d = reg_data_read_i;
            b_err_d = 1'b0;
          end else begin
            if (!we_q) a_rdata_d = reg_data_read_i;
            a_err_d = 1'b0;
          end
          state_d = ST_DONE;
        end else if (cnt_q == LAST_CNT) begin
          if (gnt_b_q) begin
            b_rdata_d = 8'hFF;
            b_err_d   = 1'b1;
          end else begin
            a_rdata_d = 8'hFF;
            a_err_d   = 1'b1;
          end
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DONE: begin
        last_b_d = gnt_b_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      gnt_b_q   <= 1'b0;
      last_b_q  <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= 6'd0;
      wdata_q   <= 8'd0;
      cnt_q     <= 16'd0;
      a_rdata_q <= 8'd0;
      a_err_q   <= 1'b0;
      b_rdata_q <= 8'd0;
      b_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_b_q   <= gnt_b_d;
      last_b_q  <= last_b_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      a_rdata_q <= a_rdata_d;
      a_err_q   <= a_err_d;
      b_rdata_q <= b_rdata_d;
      b_err_q   <= b_err_d;
    end
  end

  assign a_ack_o          = (state_q == ST_DONE) && !gnt_b_q;
  assign b_ack_o          = (state_q == ST_DONE) && gnt_b_q;
  assign a_rdata_o        = a_rdata_q;
  assign b_rdata_o        = b_rdata_q;
  assign a_err_o          = a_err_q;
  assign b_err_o          = b_err_q;
  assign reg_addr_o       = addr_q;
  assign reg_data_write_o = wdata_q;
  assign reg_write_req_o  = (state_q == ST_ISSUE) && we_q;
  assign reg_read_req_o   = (state_q == ST_ISSUE) && !we_q;
  assign busy_o           = (state_q != ST_IDLE);
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_ulpi_reg_arbiter.sv
// Bench for ulpi_reg_arbiter: a round-robin and a fixed-priority instance share the
// requester stimulus; each has its own ULPI responder and transaction-level model.
module tb_ulpi_reg_arbiter;
  localparam int unsigned TMO = 8;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [5:0] a_addr = 6'd0, b_addr = 6'd0;
  logic [7:0] a_wdata = 8'd0, b_wdata = 8'd0;
  logic [7:0] rsp_data = 8'd0;
  int         rsp_delay = 0;
  logic       man_wack = 1'b0, man_rack = 1'b0;

  logic       auto_wack [2];
  logic       auto_rack [2];
  logic       wack_in   [2];
  logic       rack_in   [2];
  logic       a_ack [2], b_ack [2], a_err [2], b_err [2];
  logic       wreq [2], rreq [2], busy [2];
  logic [7:0] a_rdata [2], b_rdata [2], wdata_o [2];
  logic [5:0] addr_o [2];
  logic [1:0] dbg_state [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign wack_in[g] = auto_wack[g] | man_wack;
    assign rack_in[g] = auto_rack[g] | man_rack;
    ulpi_reg_arbiter #(.TIMEOUT(TMO), .FIXED_PRIO(g == 1)) u_dut (
      .clk_i            (clk),
      .rst_n_i          (rst_n),
      .a_req_i          (a_req),
      .a_we_i           (a_we),
      .a_addr_i         (a_addr),
      .a_wdata_i        (a_wdata),
      .a_ack_o          (a_ack[g]),
      .a_rdata_o        (a_rdata[g]),
      .a_err_o          (a_err[g]),
      .b_req_i          (b_req),
      .b_we_i           (b_we),
      .b_addr_i         (b_addr),
      .b_wdata_i        (b_wdata),
      .b_ack_o          (b_ack[g]),
      .b_rdata_o        (b_rdata[g]),
      .b_err_o          (b_err[g]),
      .reg_addr_o       (addr_o[g]),
      .reg_data_write_o (wdata_o[g]),
      .reg_write_req_o  (wreq[g]),
      .reg_read_req_o   (rreq[g]),
      .reg_write_ack_i  (wack_in[g]),
      .reg_read_ack_i   (rack_in[g]),
      .reg_data_read_i  (rsp_data),
      .busy_o           (busy[g]),
      .dbg_state_o      (dbg_state[g])
    );
  end

  // ---------------- counters / scoreboard ----------------
  int         n_cmp = 0, n_fail = 0;
  int         n_ack [2];
  logic [0:0] exp_q0[$];
  logic [0:0] exp_q1[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic string nm(input int i, input string s);
    return $sformatf("d%0d_%s", i, s);
  endfunction

  // ---------------- ULPI responder ----------------
  // Acks the request type being driven once it has been high rsp_delay cycles (0 = never).
  int rcnt [2];
  initial begin
    for (int i = 0; i < 2; i++) begin
      auto_wack[i] = 1'b0;
      auto_rack[i] = 1'b0;
      rcnt[i]      = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (wreq[i] || rreq[i]) rcnt[i]++;
        else rcnt[i] = 0;
        auto_wack[i] = (rsp_delay != 0) && (rcnt[i] == rsp_delay) && wreq[i];
        auto_rack[i] = (rsp_delay != 0) && (rcnt[i] == rsp_delay) && rreq[i];
      end
    end
  end

  // ---------------- transaction model ----------------
  bit         m_issue [2], m_done [2], m_gb [2], m_last_b [2], m_we [2];
  logic [5:0] m_addr [2];
  logic [7:0] m_wdata [2];
  int         m_n [2];
  logic [7:0] m_rd [2][2];
  bit         m_er [2][2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_issue[i] = 0; m_done[i] = 0; m_gb[i] = 0; m_last_b[i] = 1; m_we[i] = 0;
      m_addr[i] = 6'd0; m_wdata[i] = 8'd0; m_n[i] = 0;
      for (int p = 0; p < 2; p++) begin
        m_rd[i][p] = 8'd0;
        m_er[i][p] = 0;
      end
    end
  endtask

  task automatic model_step(input int i);
    bit hit, pb;
    if (m_done[i]) begin
      m_last_b[i] = m_gb[i];
      m_done[i]   = 0;
    end else if (m_issue[i]) begin
      m_n[i]++;
      hit = m_we[i] ? wack_in[i] : rack_in[i];
      if (hit) begin
        if (!m_we[i]) m_rd[i][m_gb[i]] = rsp_data;
        m_er[i][m_gb[i]] = 0;
        m_issue[i] = 0;
        m_done[i]  = 1;
      end else if (m_n[i] == TMO) begin
        m_rd[i][m_gb[i]] = 8'hFF;
        m_er[i][m_gb[i]] = 1;
        m_issue[i] = 0;
        m_done[i]  = 1;
      end
    end else if (a_req || b_req) begin
      if (a_req && b_req) pb = (i == 1) ? 1'b0 : !m_last_b[i];
      else pb = b_req;
      m_gb[i]    = pb;
      m_issue[i] = 1;
      m_n[i]     = 0;
      m_we[i]    = pb ? b_we : a_we;
      m_addr[i]  = pb ? b_addr : a_addr;
      m_wdata[i] = pb ? b_wdata : a_wdata;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  // ---------------- per-cycle compare ----------------
  int gap [2];
  bit gap_seen [2], prev_req [2];
  initial begin
    logic [0:0] e;
    bit r;
    for (int i = 0; i < 2; i++) begin
      n_ack[i] = 0; gap[i] = 0; gap_seen[i] = 0; prev_req[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk(nm(i, "reg_write_req"), wreq[i], m_issue[i] && m_we[i]);
        chk(nm(i, "reg_read_req"), rreq[i], m_issue[i] && !m_we[i]);
        chk(nm(i, "reg_addr"), addr_o[i], m_addr[i]);
        chk(nm(i, "reg_data_write"), wdata_o[i], m_wdata[i]);
        chk(nm(i, "a_ack"), a_ack[i], m_done[i] && !m_gb[i]);
        chk(nm(i, "b_ack"), b_ack[i], m_done[i] && m_gb[i]);
        chk(nm(i, "a_rdata"), a_rdata[i], m_rd[i][0]);
        chk(nm(i, "b_rdata"), b_rdata[i], m_rd[i][1]);
        chk(nm(i, "busy"), busy[i], m_issue[i] || m_done[i]);
        if (m_done[i])
          chk(nm(i, "ack_err"), m_gb[i] ? b_err[i] : a_err[i], m_er[i][m_gb[i]]);
        if (a_ack[i] || b_ack[i]) begin
          n_ack[i]++;
          if (i == 0 && exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            chk("d0_grant_order", b_ack[i], e);
          end
          if (i == 1 && exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            chk("d1_grant_order", b_ack[i], e);
          end
        end
        r = wreq[i] || rreq[i];
        if (!rst_n) begin
          gap_seen[i] = 0;
          gap[i]      = 0;
        end else begin
          if (r && !prev_req[i] && gap_seen[i]) chk(nm(i, "req_gap_ge2"), gap[i] >= 2, 1);
          if (r) begin
            gap[i]      = 0;
            gap_seen[i] = 1;
          end else begin
            gap[i]++;
          end
        end
        prev_req[i] = r;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acks(input int i, input int target, input string name);
    int k;
    k = 0;
    while (n_ack[i] < target && k < 200) begin
      tick();
      k++;
    end
    chk(name, n_ack[i] >= target, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int rr_cnt, ack_cnt, ack_cyc, ack_err, stray, wcnt, base0, base1;
    logic [7:0] ack_rd;
    logic [5:0] seen_addr;
    logic [7:0] seen_wdata;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy[0], 0);
    chk("rst_a_rdata", a_rdata[0], 0);
    chk("rst_reg_req", wreq[0] | rreq[0], 0);
    rst_n = 1'b1;

    // A read of 0x16, PHY acks in the third request cycle with 0x5A
    rsp_data = 8'h5A; rsp_delay = 3; a_we = 1'b0; a_addr = 6'h16;
    tick();
    a_req = 1'b1;
    rr_cnt = 0; ack_cnt = 0; ack_cyc = 0; ack_err = 1; ack_rd = 8'd0; stray = 0; seen_addr = 6'd0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 5) a_req = 1'b0;
      @(negedge clk);
      if (rreq[0]) rr_cnt++;
      if (c == 1) seen_addr = addr_o[0];
      if (a_ack[0]) begin
        ack_cnt++; ack_cyc = c; ack_rd = a_rdata[0]; ack_err = a_err[0];
      end
      if (b_ack[0] || b_err[0] || b_rdata[0] != 8'd0) stray++;
    end
    chk("t1_read_req_cycles", rr_cnt, 3);
    chk("t1_reg_addr", seen_addr, 8'h16);
    chk("t1_a_ack_cycles", ack_cnt, 1);
    chk("t1_a_ack_cycle", ack_cyc, 4);
    chk("t1_a_rdata", ack_rd, 8'h5A);
    chk("t1_a_err", ack_err, 0);
    chk("t1_b_quiet", stray, 0);

    // Both request continuously: instance 0 alternates, instance 1 starves B
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rsp_data = 8'hC3; rsp_delay = 2;
    a_we = 1'b0; b_we = 1'b0; a_addr = 6'h01; b_addr = 6'h02;
    exp_q0 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    exp_q1 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    base0 = n_ack[0]; base1 = n_ack[1];
    a_req = 1'b1; b_req = 1'b1;
    wait_acks(0, base0 + 6, "t2_six_acks");
    a_req = 1'b0;
    wait_acks(1, base1 + 7, "t2_b_served");
    b_req = 1'b0;
    repeat (4) tick();
    chk("t2_d0_order_done", exp_q0.size(), 0);
    chk("t2_d1_order_done", exp_q1.size(), 0);

    // B write with no PHY ack: watchdog abort, then a late write ack in IDLE
    rsp_delay = 0; b_we = 1'b1; b_addr = 6'h0A; b_wdata = 8'h66;
    tick();
    b_req = 1'b1;
    wcnt = 0; ack_cnt = 0; ack_cyc = 0; ack_err = 0; ack_rd = 8'd0; stray = 0;
    seen_addr = 6'd0; seen_wdata = 8'd0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 10) begin
        b_req = 1'b0;
        man_wack = 1'b1;
      end
      if (c == 11) man_wack = 1'b0;
      @(negedge clk);
      if (wreq[0]) wcnt++;
      if (c == 1) begin
        seen_addr = addr_o[0];
        seen_wdata = wdata_o[0];
      end
      if (b_ack[0]) begin
        ack_cnt++; ack_cyc = c; ack_err = b_err[0]; ack_rd = b_rdata[0];
      end
      if (c >= 10 && (busy[0] || wreq[0] || rreq[0])) stray++;
    end
    chk("t3_write_req_cycles", wcnt, 8);
    chk("t3_reg_addr", seen_addr, 8'h0A);
    chk("t3_reg_wdata", seen_wdata, 8'h66);
    chk("t3_b_ack_cycles", ack_cnt, 1);
    chk("t3_b_ack_cycle", ack_cyc, 9);
    chk("t3_b_err", ack_err, 1);
    chk("t3_b_rdata", ack_rd, 8'hFF);
    chk("t3_late_ack_ignored", stray, 0);

    // A write: a read ack is the wrong type, the later write ack completes it
    a_we = 1'b1; a_addr = 6'h05; a_wdata = 8'h33;
    tick();
    a_req = 1'b1;
    wcnt = 0; ack_cnt = 0; ack_cyc = 0; ack_err = 1; ack_rd = 8'd0;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 2) man_rack = 1'b1;
      if (c == 3) man_rack = 1'b0;
      if (c == 5) man_wack = 1'b1;
      if (c == 6) man_wack = 1'b0;
      if (c == 7) a_req = 1'b0;
      @(negedge clk);
      if (wreq[0]) wcnt++;
      if (a_ack[0]) begin
        ack_cnt++; ack_cyc = c; ack_err = a_err[0]; ack_rd = a_rdata[0];
      end
    end
    chk("t4_write_req_cycles", wcnt, 5);
    chk("t4_a_ack_cycles", ack_cnt, 1);
    chk("t4_a_ack_cycle", ack_cyc, 6);
    chk("t4_a_err", ack_err, 0);
    chk("t4_a_rdata_kept", ack_rd, 8'hC3);

    // Reset between edges while a read is outstanding
    a_we = 1'b0; a_addr = 6'h20;
    tick();
    a_req = 1'b1;
    repeat (3) tick();
    chk("t5_in_issue", rreq[0], 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    a_req = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk(nm(i, "t5_rst_reqs"), wreq[i] | rreq[i], 0);
      chk(nm(i, "t5_rst_busy"), busy[i], 0);
      chk(nm(i, "t5_rst_addr"), addr_o[i], 0);
      chk(nm(i, "t5_rst_wdata"), wdata_o[i], 0);
      chk(nm(i, "t5_rst_acks"), a_ack[i] | b_ack[i], 0);
      chk(nm(i, "t5_rst_errs"), a_err[i] | b_err[i], 0);
      chk(nm(i, "t5_rst_a_rdata"), a_rdata[i], 0);
      chk(nm(i, "t5_rst_b_rdata"), b_rdata[i], 0);
    end
    tick();
    tick();
    rst_n = 1'b1;
    stray = 0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      @(negedge clk);
      for (int i = 0; i < 2; i++) if (wreq[i] || rreq[i] || busy[i]) stray++;
    end
    chk("t5_quiet_after_reset", stray, 0);
    rsp_delay = 2; b_we = 1'b0; b_addr = 6'h07;
    exp_q0 = '{1'b0, 1'b1};
    exp_q1 = '{1'b0, 1'b1};
    base0 = n_ack[0];
    a_req = 1'b1; b_req = 1'b1;
    wait_acks(0, base0 + 1, "t5_first_ack");
    a_req = 1'b0;
    wait_acks(0, base0 + 2, "t5_second_ack");
    b_req = 1'b0;
    repeat (4) tick();
    chk("t5_d0_order_done", exp_q0.size(), 0);
    chk("t5_d1_order_done", exp_q1.size(), 0);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
